remote_key_buffer: RTL and testbench



---
 rtl/remote_key_buffer_if.sv | 56 +++++
 rtl/remote_key_buffer.sv | 167 ++++++++++++++++
 tb/tb_remote_key_buffer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/remote_key_buffer_if.sv
// ---------------------------------------------------------------------------
// remote_key_buffer_if
//   Bus between the IR remote decoder, the key buffer and the consumer
//   (display/command logic).
//
//   Signals:
//     key_in        decoder key code; all-ones means "no key"
//     key_valid     decoder ready level; may stay high for several cycles
//     key_out       head-of-FIFO key code; all-ones when the FIFO is empty
//     key_out_valid FIFO holds at least one entry
//     key_out_ack   consumer pops the head entry
//     count         number of occupied FIFO entries
//     overflow      one-cycle pulse: event dropped because the FIFO was full
//     rep_drop      one-cycle pulse: event dropped as an auto-repeat
//
//   Modports:
//     master  drives the decoder and consumer side (key_in/key_valid/ack)
//     slave   the buffer itself
// ---------------------------------------------------------------------------
interface remote_key_buffer_if #(
    parameter int KEY_W = 8,
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [KEY_W-1:0] key_in;
    logic             key_valid;
    logic [KEY_W-1:0] key_out;
    logic             key_out_valid;
    logic             key_out_ack;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             rep_drop;

    modport master (
        output key_in,
        output key_valid,
        output key_out_ack,
        input  key_out,
        input  key_out_valid,
        input  count,
        input  overflow,
        input  rep_drop
    );

    modport slave (
        input  key_in,
        input  key_valid,
        input  key_out_ack,
        output key_out,
        output key_out_valid,
        output count,
        output overflow,
        output rep_drop
    );
endinterface

// File: rtl/remote_key_buffer.sv
// ---------------------------------------------------------------------------
// remote_key_buffer
//   Sits behind the IR remote decoder. Each rising edge of the decoder ready
//   level becomes one key event; auto-repeats of the same key within a
//   HOLD_CYCLES window are dropped; surviving events are queued in a small
//   first-word-fall-through FIFO and handed to the consumer over a
//   valid/ack handshake.
//
//   Parameters:
//     DEPTH        FIFO entries (power of 2, >= 2)
//     KEY_W        key code width
//     HOLD_CYCLES  repeat-suppression window in clk cycles (>= 1)
//
//   Ports:
//     clk       system clock, all logic on posedge
//     rst       synchronous, active-high reset
//     bus       remote_key_buffer_if.slave (key in, FIFO out, status pulses)
//     event_cnt [15:0] saturating count of accepted pushes
//               (present only when REMOTE_KEY_STATS_EN is defined)
//
//   Build option: define REMOTE_KEY_STATS_EN to add the event_cnt output.
// ---------------------------------------------------------------------------
module remote_key_buffer #(
    parameter int DEPTH       = 4,
    parameter int KEY_W       = 8,
    parameter int HOLD_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst,
`ifdef REMOTE_KEY_STATS_EN
    output logic [15:0]               event_cnt,
`endif
    remote_key_buffer_if.slave        bus
);
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [HOLD_W-1:0] HOLD_LOAD  = HOLD_W'(HOLD_CYCLES);
    localparam logic [KEY_W-1:0]  IDLE_KEY   = '1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [KEY_W-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_out_valid;
    logic              r_key_valid_q;
    logic [KEY_W-1:0]  r_last_key;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_overflow;
    logic              r_rep_drop;

    // ------------------------------------------------------------------
    // Event detection and filtering
    // ------------------------------------------------------------------
    logic              w_event;
    logic              w_live;
    logic              w_repeat;
    logic              w_push_req;
    logic              w_pop;
    logic              w_push;
    logic [CNT_W-1:0]  w_count_nxt;

    // One event per rising edge of the decoder ready level.
    assign w_event    = bus.key_valid & ~r_key_valid_q;

    // Idle-code events are invisible: they must not touch last_key/hold_cnt.
    assign w_live     = w_event & (bus.key_in != IDLE_KEY);

    assign w_repeat   = w_live & (bus.key_in == r_last_key) & (r_hold_cnt != '0);
    assign w_push_req = w_live & ~w_repeat;

    assign w_pop      = r_out_valid & bus.key_out_ack;

    // A full FIFO still accepts when the head is popped in the same cycle.
    assign w_push     = w_push_req & ((r_count != FULL_COUNT) | w_pop);

    always_comb begin
        w_count_nxt = r_count;
        if (w_push & ~w_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (w_pop & ~w_push) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_valid_q <= 1'b0;
            r_last_key    <= IDLE_KEY;
            r_hold_cnt    <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_out_valid   <= 1'b0;
            r_overflow    <= 1'b0;
            r_rep_drop    <= 1'b0;
        end else begin
            r_key_valid_q <= bus.key_valid;

            // Suppressed repeats also restart the window, so a held key that
            // keeps re-triggering stays suppressed.
            if (w_live) begin
                r_last_key <= bus.key_in;
                r_hold_cnt <= HOLD_LOAD;
            end else if (r_hold_cnt != '0) begin
                r_hold_cnt <= r_hold_cnt - 1'b1;
            end

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end

            r_count     <= w_count_nxt;
            r_out_valid <= (w_count_nxt != '0);

            r_overflow  <= w_push_req & ~w_push;
            r_rep_drop  <= w_repeat;
        end
    end

    // ------------------------------------------------------------------
    // Storage: contents need no reset, occupancy is tracked by r_count.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr] <= bus.key_in;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (first-word-fall-through)
    // ------------------------------------------------------------------
    assign bus.key_out       = r_out_valid ? r_mem[r_rd_ptr] : IDLE_KEY;
    assign bus.key_out_valid = r_out_valid;
    assign bus.count         = r_count;
    assign bus.overflow      = r_overflow;
    assign bus.rep_drop      = r_rep_drop;

`ifdef REMOTE_KEY_STATS_EN
    // ------------------------------------------------------------------
    // Accepted-push statistics, saturating.
    // ------------------------------------------------------------------
    logic [15:0] r_event_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_event_cnt <= '0;
        end else if (w_push && (r_event_cnt != '1)) begin
            r_event_cnt <= r_event_cnt + 1'b1;
        end
    end

    assign event_cnt = r_event_cnt;
`endif

endmodule

// File: tb/tb_remote_key_buffer.sv
// ---------------------------------------------------------------------------
// tb_remote_key_buffer
//   Directed self-checking bench for remote_key_buffer
//   (DEPTH=4, KEY_W=8, HOLD_CYCLES=16).
// ---------------------------------------------------------------------------
module tb_remote_key_buffer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    remote_key_buffer_if #(.KEY_W(8), .DEPTH(4)) bus_if ();

`ifdef REMOTE_KEY_STATS_EN
    logic [15:0] event_cnt;
`endif

    remote_key_buffer #(
        .DEPTH       (4),
        .KEY_W       (8),
        .HOLD_CYCLES (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef REMOTE_KEY_STATS_EN
        .event_cnt (event_cnt),
`endif
        .bus       (bus_if)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Raise key_valid with a key; the event is taken at the next edge.
    task automatic press_start(input logic [7:0] key);
        bus_if.key_in    = key;
        bus_if.key_valid = 1'b1;
        tick();
    endtask

    task automatic release_key();
        bus_if.key_valid = 1'b0;
        bus_if.key_in    = 8'hFF;
        tick();
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] key);
        check(tag, 32'(bus_if.key_out), 32'(key));
        bus_if.key_out_ack = 1'b1;
        tick();
        bus_if.key_out_ack = 1'b0;
    endtask

    logic [7:0] exp_order [4];
    logic [7:0] exp_order4 [4];

    initial begin
        bus_if.key_in      = 8'hFF;
        bus_if.key_valid   = 1'b0;
        bus_if.key_out_ack = 1'b0;
        exp_order  = '{8'h01, 8'h02, 8'h03, 8'h04};
        exp_order4 = '{8'h02, 8'h03, 8'h04, 8'h07};

        // 1: reset state, then a 3-cycle ready level gives one entry
        ticks(2);
        rst = 1'b0;
        check("rst_count",    32'(bus_if.count), 32'd0);
        check("rst_valid",    32'(bus_if.key_out_valid), 32'd0);
        check("rst_key_out",  32'(bus_if.key_out), 32'hFF);
        check("rst_overflow", 32'(bus_if.overflow), 32'd0);
        check("rst_rep_drop", 32'(bus_if.rep_drop), 32'd0);
`ifdef REMOTE_KEY_STATS_EN
        check("rst_event_cnt", 32'(event_cnt), 32'd0);
`endif
        press_start(8'h05);
        check("s1_valid",   32'(bus_if.key_out_valid), 32'd1);
        check("s1_key_out", 32'(bus_if.key_out), 32'h05);
        check("s1_count",   32'(bus_if.count), 32'd1);
        ticks(2);
        release_key();
        check("s1_single_entry", 32'(bus_if.count), 32'd1);

        // 2: quick re-press of the same key is a repeat; a late one is not
        ticks(2);
        press_start(8'h05);
        check("s2_rep_drop", 32'(bus_if.rep_drop), 32'd1);
        check("s2_count",    32'(bus_if.count), 32'd1);
        release_key();
        check("s2_rep_drop_end", 32'(bus_if.rep_drop), 32'd0);
        ticks(20);
        press_start(8'h05);
        check("s2_late_count",    32'(bus_if.count), 32'd2);
        check("s2_late_rep_drop", 32'(bus_if.rep_drop), 32'd0);
        release_key();
        bus_if.key_out_ack = 1'b1;
        ticks(2);
        bus_if.key_out_ack = 1'b0;
        check("s2_drained", 32'(bus_if.count), 32'd0);

        // 3: fill to DEPTH, overflow on the fifth, drain in order
        press_start(8'h01); release_key();
        press_start(8'h02); release_key();
        press_start(8'h03); release_key();
        press_start(8'h04); release_key();
        check("s3_full_count", 32'(bus_if.count), 32'd4);
        press_start(8'h06);
        check("s3_overflow", 32'(bus_if.overflow), 32'd1);
        check("s3_count",    32'(bus_if.count), 32'd4);
        check("s3_head",     32'(bus_if.key_out), 32'h01);
        release_key();
        check("s3_overflow_end", 32'(bus_if.overflow), 32'd0);
        for (int i = 0; i < 4; i++) pop_expect("s3_pop", exp_order[i]);
        check("s3_empty_valid", 32'(bus_if.key_out_valid), 32'd0);
        check("s3_empty_key",   32'(bus_if.key_out), 32'hFF);

        // 4: push while full with a simultaneous pop is accepted
        press_start(8'h01); release_key();
        press_start(8'h02); release_key();
        press_start(8'h03); release_key();
        press_start(8'h04); release_key();
        bus_if.key_out_ack = 1'b1;
        press_start(8'h07);
        bus_if.key_out_ack = 1'b0;
        check("s4_overflow", 32'(bus_if.overflow), 32'd0);
        check("s4_count",    32'(bus_if.count), 32'd4);
        check("s4_head",     32'(bus_if.key_out), 32'h02);
        release_key();
        check("s4_overflow_end", 32'(bus_if.overflow), 32'd0);
`ifdef REMOTE_KEY_STATS_EN
        check("s4_event_cnt", 32'(event_cnt), 32'd11);
`endif
        for (int i = 0; i < 4; i++) pop_expect("s4_pop", exp_order4[i]);
        check("s4_empty", 32'(bus_if.count), 32'd0);

        // 5: idle-code events are ignored and do not disturb the window
        press_start(8'hFF);
        check("s5_idle_count",    32'(bus_if.count), 32'd0);
        check("s5_idle_rep_drop", 32'(bus_if.rep_drop), 32'd0);
        check("s5_idle_overflow", 32'(bus_if.overflow), 32'd0);
        check("s5_idle_valid",    32'(bus_if.key_out_valid), 32'd0);
        release_key();
        press_start(8'h05);
        check("s5_accept_count", 32'(bus_if.count), 32'd1);
        release_key();
        press_start(8'hFF);
        release_key();
        press_start(8'h05);
        check("s5_rep_drop", 32'(bus_if.rep_drop), 32'd1);
        check("s5_count",    32'(bus_if.count), 32'd1);
        release_key();

        // 6: reset with entries queued clears everything, including last_key
        press_start(8'h0A); release_key();
        press_start(8'h0B); release_key();
        check("s6_pre_count", 32'(bus_if.count), 32'd3);
        rst = 1'b1;
        tick();
        check("s6_rst_count", 32'(bus_if.count), 32'd0);
        check("s6_rst_valid", 32'(bus_if.key_out_valid), 32'd0);
        check("s6_rst_key",   32'(bus_if.key_out), 32'hFF);
`ifdef REMOTE_KEY_STATS_EN
        check("s6_rst_event_cnt", 32'(event_cnt), 32'd0);
`endif
        rst = 1'b0;
        press_start(8'h0B);
        check("s6_count",    32'(bus_if.count), 32'd1);
        check("s6_key_out",  32'(bus_if.key_out), 32'h0B);
        check("s6_rep_drop", 32'(bus_if.rep_drop), 32'd0);
        release_key();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
